readout_accumulator: RTL and testbench

- Producer end of the state-discriminator input interface.
- Integrates streamed signed I/Q ADC samples over a programmable readout window.
- Presents the two sums as one packed word and issues a single-cycle start_trigger, gated by the discriminator's ready.
- Sits between the demodulated-sample stream and state_disc, driving its accumulated_data and start_trigger inputs.

---
 rtl/readout_accumulator.sv | 143 ++++++++++++++
 tb/tb_readout_accumulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/readout_accumulator.sv
// Windowed I/Q integrator feeding state_disc: sums signed samples with saturation
// over a programmable window, then hands {I_sum, Q_sum} over with a one-cycle trigger.

module readout_acc_lane #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [ACC_WIDTH-1:0]    acc_nxt,
    output logic                    sat
);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    always_comb begin
        sum     = {acc[ACC_WIDTH-1], acc}
                + {{(ACC_WIDTH+1-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
        ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        sat     = en && !clr && ovf;
        acc_nxt = acc;
        if (clr)
            acc_nxt = '0;
        else if (en)
            acc_nxt = ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else     acc <= acc_nxt;
    end
endmodule

module readout_accumulator #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int LEN_WIDTH    = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     window_start,
    input  logic [LEN_WIDTH-1:0]     window_len,
    input  logic                     sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]  sample_i,
    input  logic [SAMPLE_WIDTH-1:0]  sample_q,
    input  logic                     disc_ready,
    output logic [2*ACC_WIDTH-1:0]   accumulated_data,
    output logic                     start_trigger,
    output logic                     busy,
    output logic                     sat_flag,
    output logic                     len_err,
    output logic [7:0]               drop_count
);
    localparam int NUM_LANES = 2;  // lane 1 = I (upper half), lane 0 = Q

    typedef enum logic [1:0] {IDLE, ACCUM, WAIT_DISC, FIRE} state_t;

    state_t state, state_d;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 acc_clr, acc_en, accept;

    logic [NUM_LANES-1:0][SAMPLE_WIDTH-1:0] lane_smp;
    logic [NUM_LANES-1:0][ACC_WIDTH-1:0]    lane_nxt;
    logic [NUM_LANES-1:0]                   lane_sat;

    assign lane_smp = {sample_i, sample_q};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        readout_acc_lane #(
            .SAMPLE_WIDTH(SAMPLE_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .clr    (acc_clr),
            .en     (acc_en),
            .sample (lane_smp[g]),
            .acc_nxt(lane_nxt[g]),
            .sat    (lane_sat[g])
        );
    end

    assign accept = (state == IDLE) && window_start && (window_len != '0);
    assign busy   = (state != IDLE);

    always_comb begin
        state_d = state;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_d = ACCUM;
                acc_clr = 1'b1;
            end
            ACCUM: if (sample_valid) begin
                acc_en = 1'b1;
                if (remaining == LEN_WIDTH'(1))
                    state_d = disc_ready ? FIRE : WAIT_DISC;
            end
            WAIT_DISC: if (disc_ready) state_d = FIRE;
            FIRE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            remaining        <= '0;
            accumulated_data <= '0;
            start_trigger    <= 1'b0;
            sat_flag         <= 1'b0;
            len_err          <= 1'b0;
            drop_count       <= '0;
        end else begin
            state         <= state_d;
            start_trigger <= (state_d == FIRE);
            // Capture the post-update sums so the last sample lands in the trigger cycle.
            if (state_d == FIRE)
                accumulated_data <= lane_nxt;
            if (accept)
                remaining <= window_len;
            else if (acc_en)
                remaining <= remaining - LEN_WIDTH'(1);
            if (accept)
                sat_flag <= 1'b0;
            else if (|lane_sat)
                sat_flag <= 1'b1;
            if ((state == IDLE) && window_start && (window_len == '0))
                len_err <= 1'b1;
            if (window_start && (state != IDLE) && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_readout_accumulator.sv
// Directed bench for readout_accumulator: a 32-bit and an 18-bit accumulator
// instance share one stimulus stream.
`timescale 1ns/1ps
module tb_readout_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        window_start = 1'b0;
    logic [11:0] window_len = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_i = '0;
    logic [15:0] sample_q = '0;
    logic        disc_ready = 1'b1;

    logic [63:0] data32;
    logic        trig32, busy32, sat32, lerr32;
    logic [7:0]  drop32;
    logic [35:0] data18;
    logic        trig18, busy18, sat18, lerr18;
    logic [7:0]  drop18;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    readout_accumulator u_dut (
        .clk(clk), .rst(rst), .window_start(window_start), .window_len(window_len),
        .sample_valid(sample_valid), .sample_i(sample_i), .sample_q(sample_q),
        .disc_ready(disc_ready), .accumulated_data(data32), .start_trigger(trig32),
        .busy(busy32), .sat_flag(sat32), .len_err(lerr32), .drop_count(drop32)
    );

    readout_accumulator #(.ACC_WIDTH(18)) u_sat (
        .clk(clk), .rst(rst), .window_start(window_start), .window_len(window_len),
        .sample_valid(sample_valid), .sample_i(sample_i), .sample_q(sample_q),
        .disc_ready(disc_ready), .accumulated_data(data18), .start_trigger(trig18),
        .busy(busy18), .sat_flag(sat18), .len_err(lerr18), .drop_count(drop18)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int len);
        window_start = 1'b1;
        window_len   = 12'(len);
        tick();
        window_start = 1'b0;
    endtask

    task automatic feed(input int i, input int q);
        sample_valid = 1'b1;
        sample_i     = 16'(i);
        sample_q     = 16'(q);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_data", data32, 64'h0);
        check("rst_trig", {63'h0, trig32}, 64'h0);
        check("rst_busy", {63'h0, busy32}, 64'h0);
        check("rst_flags", {61'h0, sat32, lerr32, trig18}, 64'h0);
        check("rst_drop", {56'h0, drop32}, 64'h0);
        rst = 1'b0;
        tick();

        // Basic window: I=260, Q=10
        arm(4);
        check("basic_busy", {63'h0, busy32}, 64'h1);
        feed(100, 1);
        feed(200, 2);
        feed(-50, 3);
        check("basic_no_early_trig", {63'h0, trig32}, 64'h0);
        feed(10, 4);
        check("basic_trig", {63'h0, trig32}, 64'h1);
        check("basic_data", data32, 64'h00000104_0000000A);
        tick();
        check("basic_trig_1cyc", {63'h0, trig32}, 64'h0);
        check("basic_idle", {63'h0, busy32}, 64'h0);
        check("basic_hold", data32, 64'h00000104_0000000A);

        // Gapped samples
        arm(4);
        feed(100, 1);  idle(3);
        feed(200, 2);  idle(3);
        feed(-50, 3);  idle(3);
        check("gap_no_trig", {63'h0, trig32}, 64'h0);
        feed(10, 4);
        check("gap_trig", {63'h0, trig32}, 64'h1);
        check("gap_data", data32, 64'h00000104_0000000A);
        tick();

        // Backpressure: I=10, Q=-4; old result must persist through WAIT_DISC
        disc_ready = 1'b0;
        arm(4);
        feed(1, -1);
        feed(2, -1);
        feed(3, -1);
        feed(4, -1);
        for (int k = 0; k < 5; k++) begin
            check("bp_no_trig", {63'h0, trig32}, 64'h0);
            check("bp_busy", {63'h0, busy32}, 64'h1);
            check("bp_hold_old", data32, 64'h00000104_0000000A);
            tick();
        end
        disc_ready = 1'b1;
        tick();
        check("bp_trig", {63'h0, trig32}, 64'h1);
        check("bp_data", data32, 64'h0000000A_FFFFFFFC);
        tick();
        check("bp_single_trig", {63'h0, trig32}, 64'h0);
        check("bp_idle", {63'h0, busy32}, 64'h0);

        // Saturation (18-bit instance clamps, 32-bit instance does not)
        arm(8);
        for (int k = 0; k < 8; k++) feed(32767, -32768);
        check("sat_trig18", {63'h0, trig18}, 64'h1);
        check("sat_data18", {28'h0, data18}, {28'h0, 18'h1FFFF, 18'h20000});
        check("sat_flag18", {63'h0, sat18}, 64'h1);
        check("sat_data32", data32, 64'h0003FFF8_FFFC0000);
        check("sat_flag32", {63'h0, sat32}, 64'h0);
        tick();
        check("sat_flag18_held", {63'h0, sat18}, 64'h1);
        arm(4);
        check("sat_clear_on_start", {63'h0, sat18}, 64'h0);
        feed(100, 1);
        feed(200, 2);
        feed(-50, 3);
        feed(10, 4);
        check("clean_data18", {28'h0, data18}, {28'h0, 18'd260, 18'd10});
        check("clean_sat18", {63'h0, sat18}, 64'h0);
        tick();

        // Illegal length, then overlapping starts (second lands on final sample)
        arm(0);
        check("len_err", {63'h0, lerr32}, 64'h1);
        check("len_err_not_busy", {63'h0, busy32}, 64'h0);
        arm(4);
        window_start = 1'b1; window_len = 12'd3;
        feed(100, 1);
        window_start = 1'b0;
        feed(200, 2);
        feed(-50, 3);
        window_start = 1'b1;
        feed(10, 4);
        window_start = 1'b0;
        check("ovl_trig", {63'h0, trig32}, 64'h1);
        check("ovl_data", data32, 64'h00000104_0000000A);
        check("ovl_drop", {56'h0, drop32}, 64'h2);
        tick();
        check("ovl_not_rearmed", {63'h0, busy32}, 64'h0);
        check("len_err_sticky", {63'h0, lerr32}, 64'h1);

        // Reset mid-window
        arm(4);
        feed(7, 7);
        feed(9, 9);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_data", data32, 64'h0);
        check("mid_rst_busy", {63'h0, busy32}, 64'h0);
        check("mid_rst_flags", {61'h0, lerr32, sat32, trig32}, 64'h0);
        check("mid_rst_drop", {56'h0, drop32}, 64'h0);
        tick();
        check("mid_rst_no_trig", {63'h0, trig32}, 64'h0);
        rst = 1'b0;
        tick();
        arm(4);
        feed(100, 1);
        feed(200, 2);
        feed(-50, 3);
        feed(10, 4);
        check("post_rst_trig", {63'h0, trig32}, 64'h1);
        check("post_rst_data", data32, 64'h00000104_0000000A);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
